mc_frame_driver: RTL and testbench

Frame-level initiator for the Monte-Carlo FFT/multiply/IFFT core. Holds one 256-sample input frame (x_real, delta_real, delta_img) loaded by the host. On `start`, it streams the frame into the core as one contiguous in_valid burst. It then collects the core's 256-sample complex output burst into a result buffer, measures core latency and reports done/timeout. It sits between the host/testbench register side and the core's streaming ports.

---
 rtl/mc_frame_driver.sv | 240 ++++++++++++++++++++++++
 tb/tb_mc_frame_driver.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_frame_driver.sv
`default_nettype none
// ============================================================================
// Module   : mc_frame_driver
// Purpose  : Frame-level initiator for the Monte-Carlo FFT/multiply/IFFT core.
//            Holds one N-sample input frame that the host loads. On start it
//            streams the frame into the core as one contiguous burst. It then
//            collects the core's N-sample complex output into a result buffer,
//            measures the core latency and reports done or timeout.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   ld_we/ld_addr/ld_x_real/
//   ld_d_real/ld_d_img              host write port into the input frame buffer
//   start                           single-cycle frame start request
//   ready                           start will be accepted this cycle
//   busy                            frame in flight (up to and including done)
//   done                            one-cycle completion pulse
//   timeout_err                     sticky WAIT-timeout flag, cleared on start
//   lat_cycles                      first in_valid to first out_valid, saturating
//   mc_in_valid/mc_x_real/
//   mc_delta_real/mc_delta_img      registered stream into the core
//   mc_out_valid/mc_y_real/mc_y_img stream from the core
//   rd_addr/rd_y_real/rd_y_img      registered result buffer read port
// ============================================================================
module mc_frame_driver #(
    parameter int N            = 256,
    parameter int DW           = 16,
    parameter int TIMEOUT      = 1023,
    parameter int FRAME_PERIOD = 2048,
    parameter int AW           = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_x_real,
    input  logic [DW-1:0] ld_d_real,
    input  logic [DW-1:0] ld_d_img,
    input  logic          start,
    output logic          ready,
    output logic          busy,
    output logic          done,
    output logic          timeout_err,
    output logic [10:0]   lat_cycles,
    output logic          mc_in_valid,
    output logic [DW-1:0] mc_x_real,
    output logic [DW-1:0] mc_delta_real,
    output logic [DW-1:0] mc_delta_img,
    input  logic          mc_out_valid,
    input  logic [DW-1:0] mc_y_real,
    input  logic [DW-1:0] mc_y_img,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_y_real,
    output logic [DW-1:0] rd_y_img
);

    // Sample counters need one extra bit to represent the value N itself.
    localparam int CW = AW + 1;
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int PW = $clog2(FRAME_PERIOD);
    localparam int LW = 11;

    localparam logic [CW-1:0] CNT_N      = CW'(N);
    localparam logic [CW-1:0] CNT_LAST   = CW'(N - 1);
    localparam logic [WW-1:0] WAIT_LIMIT = WW'(TIMEOUT);
    localparam logic [PW-1:0] PERIOD_MAX = PW'(FRAME_PERIOD - 1);
    localparam logic [LW-1:0] LAT_MAX    = '1;
    localparam logic [AW-1:0] ADDR0      = '0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEND = 3'd1,
        S_WAIT = 3'd2,
        S_RECV = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t        state;
    logic [CW-1:0] tx_cnt;
    logic [CW-1:0] rx_cnt;
    logic [WW-1:0] wait_cnt;
    logic [PW-1:0] period_cnt;
    logic [LW-1:0] lat_cnt;

    logic [DW-1:0] frame_x  [N];
    logic [DW-1:0] frame_dr [N];
    logic [DW-1:0] frame_di [N];
    logic [DW-1:0] res_re   [N];
    logic [DW-1:0] res_im   [N];

    logic capture;
    logic last_capture;
    logic frame_complete;

    // Output samples are accepted in SEND, WAIT and RECV; the rx_cnt guard
    // keeps every result location written at most once per frame.
    assign capture        = mc_out_valid && (rx_cnt < CNT_N) &&
                            (state == S_SEND || state == S_WAIT || state == S_RECV);
    assign last_capture   = capture && (rx_cnt == CNT_LAST);
    assign frame_complete = last_capture || (rx_cnt == CNT_N);

    // The period counter saturates, so "expired" is simply "at its maximum".
    assign ready = (state == S_IDLE) && (period_cnt == PERIOD_MAX);

    // Host load port; frozen while a frame is in flight so SEND sees a stable frame.
    always_ff @(posedge clk) begin
        if (rst_n && ld_we && !busy) begin
            frame_x[ld_addr]  <= ld_x_real;
            frame_dr[ld_addr] <= ld_d_real;
            frame_di[ld_addr] <= ld_d_img;
        end
    end

    // Result buffer write port (no reset; contents are undefined after reset).
    always_ff @(posedge clk) begin
        if (rst_n && capture) begin
            res_re[rx_cnt[AW-1:0]] <= mc_y_real;
            res_im[rx_cnt[AW-1:0]] <= mc_y_img;
        end
    end

    // Registered result read port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_y_real <= '0;
            rd_y_img  <= '0;
        end else begin
            rd_y_real <= res_re[rd_addr];
            rd_y_img  <= res_im[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            tx_cnt        <= '0;
            rx_cnt        <= '0;
            wait_cnt      <= '0;
            period_cnt    <= PERIOD_MAX;
            lat_cnt       <= '0;
            lat_cycles    <= '0;
            timeout_err   <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            mc_in_valid   <= 1'b0;
            mc_x_real     <= '0;
            mc_delta_real <= '0;
            mc_delta_img  <= '0;
        end else begin
            done <= 1'b0;

            if (period_cnt != PERIOD_MAX) begin
                period_cnt <= period_cnt + 1'b1;
            end
            if (lat_cnt != LAT_MAX) begin
                lat_cnt <= lat_cnt + 1'b1;
            end

            if (capture) begin
                rx_cnt <= rx_cnt + 1'b1;
                if (rx_cnt == '0) begin
                    lat_cycles <= lat_cnt;
                end
            end

            case (state)
                S_IDLE: begin
                    if (start && ready) begin
                        // Counters restart so that they read 0 on the first SEND cycle.
                        state         <= S_SEND;
                        tx_cnt        <= CW'(1);
                        rx_cnt        <= '0;
                        lat_cnt       <= '0;
                        lat_cycles    <= '0;
                        period_cnt    <= '0;
                        timeout_err   <= 1'b0;
                        busy          <= 1'b1;
                        mc_in_valid   <= 1'b1;
                        mc_x_real     <= frame_x[ADDR0];
                        mc_delta_real <= frame_dr[ADDR0];
                        mc_delta_img  <= frame_di[ADDR0];
                    end
                end

                S_SEND: begin
                    if (tx_cnt == CNT_N) begin
                        state         <= S_WAIT;
                        wait_cnt      <= '0;
                        mc_in_valid   <= 1'b0;
                        mc_x_real     <= '0;
                        mc_delta_real <= '0;
                        mc_delta_img  <= '0;
                    end else begin
                        tx_cnt        <= tx_cnt + 1'b1;
                        mc_x_real     <= frame_x[tx_cnt[AW-1:0]];
                        mc_delta_real <= frame_dr[tx_cnt[AW-1:0]];
                        mc_delta_img  <= frame_di[tx_cnt[AW-1:0]];
                    end
                end

                S_WAIT: begin
                    // Captures that already began during SEND skip the wait.
                    if (frame_complete) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else if (capture || rx_cnt != '0) begin
                        state <= S_RECV;
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        state       <= S_DONE;
                        done        <= 1'b1;
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                S_RECV: begin
                    // Gaps in out_valid are tolerated indefinitely here.
                    if (frame_complete) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_frame_driver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mc_frame_driver
// Purpose  : Directed self-checking bench for mc_frame_driver. Inputs change
//            after the falling edge, outputs are sampled on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_frame_driver;

    localparam int N  = 256;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ld_we = 1'b0;
    logic [7:0]    ld_addr = '0;
    logic [DW-1:0] ld_x_real = '0, ld_d_real = '0, ld_d_img = '0;
    logic          start = 1'b0;
    logic          ready, busy, done, timeout_err;
    logic [10:0]   lat_cycles;
    logic          mc_in_valid;
    logic [DW-1:0] mc_x_real, mc_delta_real, mc_delta_img;
    logic          mc_out_valid = 1'b0;
    logic [DW-1:0] mc_y_real = '0, mc_y_img = '0;
    logic [7:0]    rd_addr = '0;
    logic [DW-1:0] rd_y_real, rd_y_img;

    int n_cmp  = 0;
    int n_fail = 0;
    int rel    = 0;   // cycles since the most recent first mc_in_valid

    always #5 clk = ~clk;

    mc_frame_driver dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ld_we        (ld_we),
        .ld_addr      (ld_addr),
        .ld_x_real    (ld_x_real),
        .ld_d_real    (ld_d_real),
        .ld_d_img     (ld_d_img),
        .start        (start),
        .ready        (ready),
        .busy         (busy),
        .done         (done),
        .timeout_err  (timeout_err),
        .lat_cycles   (lat_cycles),
        .mc_in_valid  (mc_in_valid),
        .mc_x_real    (mc_x_real),
        .mc_delta_real(mc_delta_real),
        .mc_delta_img (mc_delta_img),
        .mc_out_valid (mc_out_valid),
        .mc_y_real    (mc_y_real),
        .mc_y_img     (mc_y_img),
        .rd_addr      (rd_addr),
        .rd_y_real    (rd_y_real),
        .rd_y_img     (rd_y_img)
    );

    task automatic tick();
        @(negedge clk);
        rel++;
    endtask

    // x_real[k] = (k<<4)+ofs, delta = (0x7FFF, k*ofs)
    task automatic load_frame(input int ofs);
        for (int k = 0; k < N; k++) begin
            ld_we     = 1'b1;
            ld_addr   = 8'(k);
            ld_x_real = 16'((k << 4) + ofs);
            ld_d_real = 16'h7FFF;
            ld_d_img  = 16'(k * ofs);
            tick();
        end
        ld_we = 1'b0;
    endtask

    // Waits (bounded) for ready, pulses start; returns at the first valid cycle.
    task automatic start_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (ok) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            rel   = 0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({mc_in_valid, busy, done, timeout_err} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000", {mc_in_valid, busy, done, timeout_err});
        end
        n_cmp++;
        if ({mc_x_real, mc_delta_real, mc_delta_img, lat_cycles} !== '0) begin
            n_fail++; $display("FAIL reset_data: got %h/%h/%h/%0d want all 0", mc_x_real, mc_delta_real, mc_delta_img, lat_cycles);
        end
        n_cmp++;
        if ({rd_y_real, rd_y_img} !== 32'h0) begin
            n_fail++; $display("FAIL reset_rd: got %h/%h want 0/0", rd_y_real, rd_y_img);
        end
        n_cmp++;
        if (ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b want 1", ready);
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (ready !== 1'b1) begin
            n_fail++; $display("FAIL post_reset_ready: got %b want 1", ready);
        end
    endtask

    task automatic test_basic();
        bit ok;
        int vcnt = 0, vbad = 0, dcnt = 0, dbad = 0;
        load_frame(0);
        start_frame(ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL basic_start: ready got 0 want 1"); end
        for (int c = 0; c < 800; c++) begin
            if (mc_in_valid === 1'b1) vcnt++;
            if (mc_in_valid !== (c < N)) vbad++;
            if (done === 1'b1) dcnt++;
            if (done !== (c == 796)) dbad++;
            if (c == 0) begin
                n_cmp++;
                if ({mc_x_real, mc_delta_real, mc_delta_img, busy} !== {16'h0000, 16'h7FFF, 16'h0000, 1'b1}) begin
                    n_fail++; $display("FAIL basic_first: got %h/%h/%h busy=%b want 0000/7fff/0000 busy=1", mc_x_real, mc_delta_real, mc_delta_img, busy);
                end
            end
            if (c == 1) begin
                n_cmp++;
                if (mc_x_real !== 16'h0010) begin
                    n_fail++; $display("FAIL basic_second_x: got %h want 0010", mc_x_real);
                end
            end
            if (c == 255) begin
                n_cmp++;
                if (mc_x_real !== 16'h0FF0) begin
                    n_fail++; $display("FAIL basic_last_x: got %h want 0ff0", mc_x_real);
                end
            end
            if (c == 796) begin
                n_cmp++;
                if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_done: got %b want 1", busy); end
            end
            if (c == 797) begin
                n_cmp++;
                if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_fall: got %b want 0", busy); end
            end
            if (c >= 540 && c < 540 + N) begin
                mc_out_valid = 1'b1;
                mc_y_real    = 16'(c - 540);
                mc_y_img     = 16'(-(c - 540));
            end else begin
                mc_out_valid = 1'b0;
                mc_y_real    = '0;
                mc_y_img     = '0;
            end
            tick();
        end
        n_cmp++;
        if (vcnt != N || vbad != 0) begin
            n_fail++; $display("FAIL basic_burst: got %0d valid cycles (%0d misplaced) want 256 (0)", vcnt, vbad);
        end
        n_cmp++;
        if (dcnt != 1 || dbad != 0) begin
            n_fail++; $display("FAIL basic_done: got %0d pulses (%0d misplaced) want 1 at cycle 796", dcnt, dbad);
        end
        n_cmp++;
        if (lat_cycles !== 11'd540) begin
            n_fail++; $display("FAIL basic_lat: got %0d want 540", lat_cycles);
        end
        rd_addr = 8'd5;
        tick();
        n_cmp++;
        if ({rd_y_real, rd_y_img} !== {16'h0005, 16'hFFFB}) begin
            n_fail++; $display("FAIL basic_rd5: got %h/%h want 0005/fffb", rd_y_real, rd_y_img);
        end
        rd_addr = 8'd255;
        tick();
        n_cmp++;
        if ({rd_y_real, rd_y_img} !== {16'h00FF, 16'hFF01}) begin
            n_fail++; $display("FAIL basic_rd255: got %h/%h want 00ff/ff01", rd_y_real, rd_y_img);
        end
    endtask

    task automatic test_gaps();
        bit ok;
        int dcnt = 0, dbad = 0;
        load_frame(3);
        start_frame(ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL gaps_start: ready got 0 want 1"); end
        for (int c = 0; c < 820; c++) begin
            if (done === 1'b1) dcnt++;
            if (done !== (c == 811)) dbad++;
            if (c == 10) begin
                n_cmp++;
                if (mc_x_real !== 16'h00A3) begin
                    n_fail++; $display("FAIL gaps_ld_busy: got %h want 00a3", mc_x_real);
                end
            end
            if (c == 100) begin
                n_cmp++;
                if (mc_delta_img !== 16'd300) begin
                    n_fail++; $display("FAIL gaps_dimg: got %0d want 300", mc_delta_img);
                end
            end
            if (c == 810) begin
                n_cmp++;
                if (busy !== 1'b1) begin n_fail++; $display("FAIL gaps_busy: got %b want 1", busy); end
            end
            // host write attempted while busy must not land
            ld_we     = (c == 2);
            ld_addr   = 8'd10;
            ld_x_real = 16'h7777;
            if (c >= 300 && c < 300 + 2 * N && ((c - 300) % 2) == 0) begin
                mc_out_valid = 1'b1;
                mc_y_real    = 16'(16'h1000 + (c - 300) / 2);
                mc_y_img     = 16'(16'h2000 - (c - 300) / 2);
            end else if (c >= 811 && c <= 815) begin
                mc_out_valid = 1'b1;
                mc_y_real    = 16'hDEAD;
                mc_y_img     = 16'hBEEF;
            end else begin
                mc_out_valid = 1'b0;
            end
            tick();
        end
        mc_out_valid = 1'b0;
        n_cmp++;
        if (dcnt != 1 || dbad != 0) begin
            n_fail++; $display("FAIL gaps_done: got %0d pulses (%0d misplaced) want 1 at cycle 811", dcnt, dbad);
        end
        n_cmp++;
        if (lat_cycles !== 11'd300) begin
            n_fail++; $display("FAIL gaps_lat: got %0d want 300", lat_cycles);
        end
        rd_addr = 8'd0;
        tick();
        n_cmp++;
        if ({rd_y_real, rd_y_img} !== {16'h1000, 16'h2000}) begin
            n_fail++; $display("FAIL gaps_rd0: got %h/%h want 1000/2000", rd_y_real, rd_y_img);
        end
        rd_addr = 8'd200;
        tick();
        n_cmp++;
        if ({rd_y_real, rd_y_img} !== {16'h10C8, 16'h1F38}) begin
            n_fail++; $display("FAIL gaps_rd200: got %h/%h want 10c8/1f38", rd_y_real, rd_y_img);
        end
        rd_addr = 8'd255;
        tick();
        n_cmp++;
        if ({rd_y_real, rd_y_img} !== {16'h10FF, 16'h1F01}) begin
            n_fail++; $display("FAIL gaps_rd255: got %h/%h want 10ff/1f01", rd_y_real, rd_y_img);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int dbad = 0, tbad = 0;
        start_frame(ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL to_start: ready got 0 want 1"); end
        for (int c = 0; c < 1291; c++) begin
            if (done !== (c == 1280)) dbad++;
            if (timeout_err !== (c >= 1280)) tbad++;
            if (c == 10) begin
                n_cmp++;
                if (mc_x_real !== 16'h00A3) begin
                    n_fail++; $display("FAIL to_frame_kept: got %h want 00a3", mc_x_real);
                end
            end
            if (c == 1000) begin
                n_cmp++;
                if (ready !== 1'b0) begin n_fail++; $display("FAIL to_ready_busy: got %b want 0", ready); end
            end
            if (c == 1279) begin
                n_cmp++;
                if ({done, timeout_err} !== 2'b00) begin
                    n_fail++; $display("FAIL to_early: done/err got %b want 00", {done, timeout_err});
                end
            end
            if (c == 1280) begin
                n_cmp++;
                if ({done, timeout_err} !== 2'b11) begin
                    n_fail++; $display("FAIL to_fire: done/err got %b want 11", {done, timeout_err});
                end
            end
            start = (c == 1000);
            tick();
        end
        start = 1'b0;
        n_cmp++;
        if (dbad != 0 || tbad != 0) begin
            n_fail++; $display("FAIL to_profile: got %0d done / %0d err misplaced cycles want 0/0", dbad, tbad);
        end
        n_cmp++;
        if ({busy, lat_cycles} !== 12'h000) begin
            n_fail++; $display("FAIL to_idle: busy=%b lat=%0d want busy=0 lat=0", busy, lat_cycles);
        end
    endtask

    task automatic test_frame_period();
        for (int c = 1291; c <= 2048; c++) begin
            if (c == 1500) begin
                n_cmp++;
                if (ready !== 1'b0) begin n_fail++; $display("FAIL per_ready_1500: got %b want 0", ready); end
            end
            if (c == 1501) begin
                n_cmp++;
                if ({busy, mc_in_valid} !== 2'b00) begin
                    n_fail++; $display("FAIL per_ignored: busy/valid got %b want 00", {busy, mc_in_valid});
                end
            end
            if (c == 2046) begin
                n_cmp++;
                if (ready !== 1'b0) begin n_fail++; $display("FAIL per_ready_2046: got %b want 0", ready); end
            end
            if (c == 2047) begin
                n_cmp++;
                if (ready !== 1'b1) begin n_fail++; $display("FAIL per_ready_2047: got %b want 1", ready); end
            end
            start = (c == 1500 || c == 2048);
            tick();
        end
        start = 1'b0;
        n_cmp++;
        if ({mc_in_valid, busy, timeout_err} !== 3'b110) begin
            n_fail++; $display("FAIL per_accept: valid/busy/err got %b want 110", {mc_in_valid, busy, timeout_err});
        end
        rel = 0;
    endtask

    task automatic test_reset_mid();
        int vbad = 0, bad = 0;
        for (int c = 0; c < 100; c++) begin
            if (mc_in_valid !== 1'b1) vbad++;
            rst_n = (c != 99);
            tick();
        end
        n_cmp++;
        if (vbad != 0) begin n_fail++; $display("FAIL mid_burst: got %0d gaps want 0", vbad); end
        n_cmp++;
        if ({mc_in_valid, busy, done, ready} !== 4'b0001) begin
            n_fail++; $display("FAIL mid_reset: valid/busy/done/ready got %b want 0001", {mc_in_valid, busy, done, ready});
        end
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (done !== 1'b0 || mc_in_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin n_fail++; $display("FAIL mid_quiet: got %0d active cycles want 0", bad); end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if ({mc_in_valid, busy} !== 2'b11) begin
            n_fail++; $display("FAIL mid_restart: valid/busy got %b want 11", {mc_in_valid, busy});
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish within 2 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_timeout();
        test_frame_period();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
